// File: rtl/pc_txpacket_if.sv
// Handshake bundle between the PC-link packetizer, the SCCB readback FIFO and the PC-side
// transmitter.
interface pc_txpacket_if;
    logic [7:0] fifo_data;
    logic       fifo_ready;
    logic       fifo_rden;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Packetizer side
    modport master (
        input  fifo_data, fifo_ready, tx_ready,
        output fifo_rden, tx_data, tx_valid
    );

    // FIFO / transmitter side
    modport slave (
        output fifo_data, fifo_ready, tx_ready,
        input  fifo_rden, tx_data, tx_valid
    );
endinterface

// File: rtl/pc_txpacket.sv
// Transmit packetizer: reads one (addr, data) pair from the readback FIFO and streams it as a
// fixed Ethernet-style frame, followed by an inter-frame gap.
module pc_txpacket #(
    parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC   = 48'h00AA00BB00CC,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned PKT_LEN   = 60,
    parameter int unsigned IFG       = 12
) (
    input  logic          txclk,
    input  logic          txreset,
    pc_txpacket_if.master link,
    output logic          busy,
    output logic [15:0]   pkt_count
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch1 = 3'd1;
    localparam logic [2:0] StFetch2 = 3'd2;
    localparam logic [2:0] StLatch  = 3'd3;
    localparam logic [2:0] StSend   = 3'd4;
    localparam logic [2:0] StGap    = 3'd5;

    localparam logic [5:0]   LastIdx = 6'(PKT_LEN - 1);
    localparam logic [7:0]   GapLast = 8'(IFG - 1);
    localparam logic [111:0] Header  = {DST_MAC, SRC_MAC, ETHERTYPE};

    logic [2:0]  state_q, state_d;
    logic [5:0]  index_q, index_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] pkt_count_d;
    logic        rden;
    logic        accept;

    // Header bytes come from the MSB end of the concatenated header vector.
    function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [7:0] a,
                                              input logic [7:0] d);
        logic [111:0] sh;
        sh = Header << (8 * idx);
        if (idx < 6'd14)       return sh[111:104];
        else if (idx == 6'd14) return a;
        else if (idx == 6'd15) return d;
        else                   return 8'h00;
    endfunction

    assign accept         = tx_valid_q && link.tx_ready;
    assign link.fifo_rden = rden;
    assign link.tx_data   = tx_data_q;
    assign link.tx_valid  = tx_valid_q;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        gap_d       = gap_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        pkt_count_d = pkt_count;
        rden        = 1'b0;
        case (state_q)
            StIdle: begin
                if (link.fifo_ready) state_d = StFetch1;
            end
            StFetch1: begin
                rden    = 1'b1;
                state_d = StFetch2;
            end
            StFetch2: begin
                rden    = 1'b1;
                addr_d  = link.fifo_data;
                state_d = StLatch;
            end
            StLatch: begin
                data_d     = link.fifo_data;
                index_d    = 6'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = frame_byte(6'd0, addr_q, data_q);
                state_d    = StSend;
            end
            StSend: begin
                if (accept) begin
                    if (index_q == LastIdx) begin
                        tx_valid_d  = 1'b0;
                        pkt_count_d = pkt_count + 16'd1;
                        gap_d       = 8'd0;
                        state_d     = StGap;
                    end else begin
                        index_d   = index_q + 6'd1;
                        tx_data_d = frame_byte(index_q + 6'd1, addr_q, data_q);
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // pkt_count is rewritten every cycle so its stored value always tracks the next-state path.
    always_ff @(posedge txclk) begin
        if (txreset) begin
            state_q    <= StIdle;
            index_q    <= 6'd0;
            gap_q      <= 8'd0;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            pkt_count  <= 16'd0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy       <= (state_d != StIdle);
            pkt_count  <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_pc_txpacket.sv
// Self-checking bench for pc_txpacket: FIFO model, sink with selectable backpressure and a
// byte-level frame model.
module tb_pc_txpacket;
    localparam int unsigned PktLen = 60;
    localparam int unsigned Ifg    = 12;
    localparam logic [47:0] Dst    = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] Src    = 48'h00AA00BB00CC;
    localparam logic [15:0] Eth    = 16'h88B5;

    logic        txclk = 1'b0;
    logic        txreset = 1'b1;
    logic        busy;
    logic [15:0] pkt_count;

    pc_txpacket_if link();

    pc_txpacket #(
        .DST_MAC(Dst), .SRC_MAC(Src), .ETHERTYPE(Eth), .PKT_LEN(PktLen), .IFG(Ifg)
    ) dut (
        .txclk(txclk), .txreset(txreset), .link(link), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 txclk = ~txclk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge txclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- readback FIFO model ----------------
    logic [7:0] fq[$];
    int underflow = 0;
    always @(posedge txclk) begin
        if (txreset) begin
            fq.delete();
            link.fifo_data <= 8'h00;
        end else if (link.fifo_rden) begin
            if (fq.size() > 0) link.fifo_data <= fq.pop_front();
            else underflow++;
        end
    end
    always @(negedge txclk) link.fifo_ready = (fq.size() >= 2);

    // ---------------- sink + monitor ----------------
    int         bp_mode = 0;
    int         k = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] cur_q[$];
    logic [7:0] cap_bytes[$];
    int         cap_start[$];
    int         cap_len[$];
    int         cur_start = 0, cur_len = 0;
    int         mon_frames = 0, rden_cnt = 0;
    int         in_gap = 0, gap_cnt = 0, last_gap = -1;

    always @(negedge txclk) begin
        if (txreset) begin
            cur_q.delete();
            cur_len    = 0;
            in_gap     = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            k          = 0;
            link.tx_ready = 1'b1;
        end else begin
            if (link.fifo_rden) rden_cnt++;
            if (prev_valid && !prev_ready && link.tx_valid)
                check("stall_hold", int'(link.tx_data), int'(prev_data));
            if (prev_valid && !link.tx_valid) begin
                foreach (cur_q[i]) cap_bytes.push_back(cur_q[i]);
                cap_start.push_back(cur_start);
                cap_len.push_back(cur_len);
                mon_frames++;
                cur_q.delete();
                in_gap  = 1;
                gap_cnt = 1;
            end else if (in_gap != 0) begin
                if (busy && !link.tx_valid) gap_cnt++;
                else begin
                    last_gap = gap_cnt;
                    in_gap   = 0;
                end
            end
            if (link.tx_valid) begin
                if (!prev_valid) begin
                    cur_start = cyc;
                    cur_len   = 0;
                    k         = 0;
                end
                case (bp_mode)
                    0:       link.tx_ready = 1'b1;
                    1:       link.tx_ready = ((k % 4) == 0) || ((k % 4) == 3);
                    default: link.tx_ready = 1'($urandom_range(0, 1));
                endcase
                k++;
                cur_len++;
                if (link.tx_ready) cur_q.push_back(link.tx_data);
            end else begin
                link.tx_ready = 1'b1;
            end
            prev_valid = link.tx_valid;
            prev_ready = link.tx_ready;
            prev_data  = link.tx_data;
        end
    end

    // ---------------- reference frame model ----------------
    function automatic logic [7:0] model_byte(input int i, input logic [7:0] a,
                                              input logic [7:0] d);
        logic [7:0]  hdr[14];
        logic [47:0] dm;
        logic [47:0] sm;
        logic [15:0] em;
        dm = Dst;
        sm = Src;
        em = Eth;
        for (int j = 0; j < 6; j++) begin
            hdr[j]     = dm[47 - 8*j -: 8];
            hdr[6 + j] = sm[47 - 8*j -: 8];
        end
        hdr[12] = em[15:8];
        hdr[13] = em[7:0];
        if (i < 14)  return hdr[i];
        if (i == 14) return a;
        if (i == 15) return d;
        return 8'h00;
    endfunction

    task automatic check_frame(input string name, input int fidx, input logic [7:0] a,
                               input logic [7:0] d);
        int bad = 0;
        int base = fidx * int'(PktLen);
        for (int i = 0; i < int'(PktLen); i++) begin
            if (base + i >= cap_bytes.size()) bad++;
            else if (cap_bytes[base + i] !== model_byte(i, a, d)) begin
                if (bad == 0)
                    $display("  %s: byte %0d is %h, model %h", name, i, cap_bytes[base + i],
                             model_byte(i, a, d));
                bad++;
            end
        end
        check(name, bad, 0);
    endtask

    task automatic clear_caps();
        cap_bytes.delete();
        cap_start.delete();
        cap_len.delete();
        mon_frames = 0;
        last_gap   = -1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
        fq.push_back(a);
        fq.push_back(d);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (mon_frames < n && t < budget) begin
            @(negedge txclk);
            t++;
        end
        check("frames_seen", mon_frames, n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        do begin
            @(negedge txclk);
            #1;
            t++;
        end while ((busy || in_gap != 0) && t < budget);
        check("back_to_idle", int'(busy), 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         mode;
        int         exp_len;
    } vec_t;

    vec_t        tbl[8];
    logic [15:0] exp_pkt = 16'd0;
    int          r0;
    int          seen_rden, seen_valid, seen_busy;

    initial begin
        tbl[0] = '{8'h12, 8'h5A, 0, 60};
        tbl[1] = '{8'h12, 8'h5A, 1, 120};
        for (int i = 2; i < 8; i++) begin
            tbl[i].a       = 8'($urandom);
            tbl[i].d       = 8'($urandom);
            tbl[i].mode    = int'($urandom_range(0, 2));
            tbl[i].exp_len = (tbl[i].mode == 0) ? 60 : (tbl[i].mode == 1) ? 120 : -1;
        end

        // Reset state
        txreset = 1'b1;
        repeat (3) @(negedge txclk);
        check("rst_tx_valid", int'(link.tx_valid), 0);
        check("rst_tx_data", int'(link.tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pkt_count", int'(pkt_count), 0);
        check("rst_fifo_rden", int'(link.fifo_rden), 0);
        txreset = 1'b0;

        // Empty FIFO: nothing may happen
        seen_rden = 0; seen_valid = 0; seen_busy = 0;
        repeat (100) begin
            @(negedge txclk);
            #1;
            if (link.fifo_rden) seen_rden++;
            if (link.tx_valid)  seen_valid++;
            if (busy)           seen_busy++;
        end
        check("empty_rden", seen_rden, 0);
        check("empty_valid", seen_valid, 0);
        check("empty_busy", seen_busy, 0);

        // Table-driven single frames
        foreach (tbl[v]) begin
            clear_caps();
            bp_mode = tbl[v].mode;
            r0 = rden_cnt;
            push_pair(tbl[v].a, tbl[v].d);
            wait_frames(1, 2000);
            wait_idle(200);
            exp_pkt++;
            check_frame($sformatf("vec%0d_bytes", v), 0, tbl[v].a, tbl[v].d);
            check($sformatf("vec%0d_rden", v), rden_cnt - r0, 2);
            if (tbl[v].exp_len >= 0)
                check($sformatf("vec%0d_len", v), (cap_len.size() > 0) ? cap_len[0] : 0,
                      tbl[v].exp_len);
            else
                check($sformatf("vec%0d_len_min", v),
                      int'((cap_len.size() > 0) && (cap_len[0] >= int'(PktLen))), 1);
            check($sformatf("vec%0d_pkt_count", v), int'(pkt_count), int'(exp_pkt));
            check($sformatf("vec%0d_gap", v), last_gap, int'(Ifg));
        end
        bp_mode = 0;

        // Back-to-back frames
        clear_caps();
        r0 = rden_cnt;
        push_pair(8'h01, 8'hA1);
        push_pair(8'h02, 8'hA2);
        push_pair(8'h03, 8'hA3);
        wait_frames(3, 3000);
        wait_idle(200);
        exp_pkt += 16'd3;
        check_frame("b2b_f0", 0, 8'h01, 8'hA1);
        check_frame("b2b_f1", 1, 8'h02, 8'hA2);
        check_frame("b2b_f2", 2, 8'h03, 8'hA3);
        check("b2b_rden", rden_cnt - r0, 6);
        check("b2b_pkt_count", int'(pkt_count), int'(exp_pkt));
        if (cap_start.size() >= 3) begin
            check("b2b_spacing01", cap_start[1] - cap_start[0], 3 + int'(PktLen + Ifg) + 1);
            check("b2b_spacing12", cap_start[2] - cap_start[1], 3 + int'(PktLen + Ifg) + 1);
        end else begin
            check("b2b_starts", cap_start.size(), 3);
        end

        // Mid-frame reset at index 20
        clear_caps();
        push_pair(8'h33, 8'h44);
        r0 = 0;
        do begin
            @(negedge txclk);
            #1;
            r0++;
        end while (cur_q.size() != 21 && r0 < 500);
        check("mid_reached_idx20", cur_q.size(), 21);
        txreset = 1'b1;
        @(posedge txclk);
        #1;
        check("mid_valid_drop", int'(link.tx_valid), 0);
        check("mid_busy_drop", int'(busy), 0);
        check("mid_pkt_count_reset", int'(pkt_count), 0);
        @(negedge txclk);
        @(negedge txclk);
        txreset = 1'b0;
        exp_pkt = 16'd0;
        clear_caps();
        r0 = rden_cnt;
        push_pair(8'h7E, 8'hC3);
        wait_frames(1, 2000);
        wait_idle(200);
        exp_pkt++;
        check_frame("mid_next_bytes", 0, 8'h7E, 8'hC3);
        check("mid_next_rden", rden_cnt - r0, 2);
        check("mid_next_pkt_count", int'(pkt_count), int'(exp_pkt));

        // Counter wrap
        @(negedge txclk);
        force dut.pkt_count = 16'hFFFF;
        @(negedge txclk);
        release dut.pkt_count;
        @(negedge txclk);
        exp_pkt = 16'hFFFF;
        check("wrap_preload", int'(pkt_count), int'(exp_pkt));
        clear_caps();
        push_pair(8'h9C, 8'h0F);
        wait_frames(1, 2000);
        wait_idle(200);
        exp_pkt++;
        check_frame("wrap_bytes", 0, 8'h9C, 8'h0F);
        check("wrap_pkt_count", int'(pkt_count), int'(exp_pkt));

        check("fifo_underflow", underflow, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
